// File: rtl/aes128_ecb_stream_adapter_if.sv
// Bundle of every non-clock, non-reset signal of the AES-128 ECB stream adapter.
//
// Purpose: groups the key-load request, the 32-bit input word stream, the
// core-facing key/plaintext/ciphertext buses, the ciphertext output strobe
// and the block counters so they travel as one port.
//
// Signal summary:
//   key_load/key_in/key_ack   key change request, new key, one-cycle apply pulse
//   s_valid/s_ready/s_data    32-bit input word handshake (first word = [127:96])
//   key_out/text_out          key and plaintext block driven to the core
//   text_valid                one-cycle pulse when text_out holds a new block
//   cipher_in                 ciphertext returned by the core
//   m_valid/m_data            one-cycle pulse with registered ciphertext block
//   blocks_in/blocks_out      wrapping counts of issued / delivered blocks
//
// Modports: slave is the adapter side, master is the environment side.
interface aes128_ecb_stream_adapter_if #(
  parameter int CNT_W = 16
);
  logic             key_load;
  logic [127:0]     key_in;
  logic             key_ack;
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic [127:0]     key_out;
  logic [127:0]     text_out;
  logic             text_valid;
  logic [127:0]     cipher_in;
  logic             m_valid;
  logic [127:0]     m_data;
  logic [CNT_W-1:0] blocks_in;
  logic [CNT_W-1:0] blocks_out;

  modport slave (
    input  key_load, key_in, s_valid, s_data, cipher_in,
    output key_ack, s_ready, key_out, text_out, text_valid,
           m_valid, m_data, blocks_in, blocks_out
  );

  modport master (
    output key_load, key_in, s_valid, s_data, cipher_in,
    input  key_ack, s_ready, key_out, text_out, text_valid,
           m_valid, m_data, blocks_in, blocks_out
  );
endinterface

// File: rtl/aes128_ecb_stream_adapter.sv
// AES-128 ECB stream adapter wrapped around a fixed-latency encryptor core.
//
// Purpose: packs four accepted 32-bit words into one 128-bit plaintext block
// for the core, tags each issued block with a latency-matched valid bit so the
// returning ciphertext is captured with a one-cycle m_valid strobe, and
// sequences key changes (RUN -> DRAIN -> LOAD) so no block in flight ever
// sees a key different from the one it was issued under.
//
// Ports:
//   clk   single rising-edge clock
//   rst   synchronous, active-high reset
//   bus   aes128_ecb_stream_adapter_if.slave (see interface header)
//
// Parameters:
//   ENC_LATENCY  cycles from a text_out change to its ciphertext on cipher_in (>= 1)
//   CNT_W        width of the wrapping block counters
module aes128_ecb_stream_adapter #(
  parameter int ENC_LATENCY = 10,
  parameter int CNT_W       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  aes128_ecb_stream_adapter_if.slave        bus
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    LOAD
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             wordCnt_q, wordCnt_d;
  logic [95:0]            shiftBuf_q, shiftBuf_d;
  logic [127:0]           textOut_q, textOut_d;
  logic                   textValid_q, textValid_d;
  logic [ENC_LATENCY-1:0] delayLine_q, delayLine_d;
  logic [127:0]           mData_q, mData_d;
  logic                   mValid_q, mValid_d;
  logic [CNT_W-1:0]       blocksIn_q, blocksIn_d;
  logic [CNT_W-1:0]       blocksOut_q, blocksOut_d;
  logic [127:0]           keyOut_q, keyOut_d;
  logic [127:0]           keyPend_q, keyPend_d;
  logic                   sReady_q, sReady_d;

  logic                   accept;
  logic                   inFlight;
  logic                   keyAck;
  logic [ENC_LATENCY:0]   delayShift;

  // A word moves only when the registered ready and the upstream valid meet.
  assign accept = bus.s_valid && sReady_q;

  // The block issued this cycle is not yet in the delay line, so it is
  // counted explicitly; otherwise a key_load arriving with the fourth word
  // would let DRAIN fall through before that block entered the pipeline.
  assign inFlight = textValid_q | (|delayLine_q);

  // Word packing and block issue. Words 0..2 shift into a 96-bit buffer
  // (word 0 ends in the top slot); the fourth word completes the block,
  // which is registered onto text_out with a one-cycle text_valid pulse.
  always_comb begin
    wordCnt_d   = wordCnt_q;
    shiftBuf_d  = shiftBuf_q;
    textOut_d   = textOut_q;
    textValid_d = 1'b0;
    blocksIn_d  = blocksIn_q;
    if (accept) begin
      if (wordCnt_q == 2'd3) begin
        textOut_d   = {shiftBuf_q, bus.s_data};
        textValid_d = 1'b1;
        blocksIn_d  = blocksIn_q + CNT_W'(1);
        wordCnt_d   = 2'd0;
      end else begin
        shiftBuf_d  = {shiftBuf_q[63:0], bus.s_data};
        wordCnt_d   = wordCnt_q + 2'd1;
      end
    end
  end

  // Latency-matched valid tag. A text_valid in cycle T reaches the last
  // delay bit in cycle T+ENC_LATENCY, which is exactly when the core shows
  // the matching ciphertext; it is captured on that edge so m_valid and
  // m_data appear together one cycle later.
  always_comb begin
    delayShift  = {delayLine_q, textValid_q};
    delayLine_d = delayShift[ENC_LATENCY-1:0];
    mValid_d    = delayLine_q[ENC_LATENCY-1];
    mData_d     = mValid_d ? bus.cipher_in : mData_q;
    blocksOut_d = blocksOut_q + (mValid_d ? CNT_W'(1) : CNT_W'(0));
  end

  // Key-change sequencer. RUN latches a requested key and moves to DRAIN;
  // DRAIN keeps accepting words only to finish a partial block, keeps the
  // newest requested key, and waits until nothing is left in the core or on
  // the output strobe. The key is copied to key_out on the edge entering
  // LOAD so that key_out and key_ack change in the same cycle. Ready is
  // computed from the next state and next word count so the registered
  // s_ready always matches the state it is presented with.
  always_comb begin
    state_d   = state_q;
    keyPend_d = keyPend_q;
    keyOut_d  = keyOut_q;
    keyAck    = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.key_load) begin
          keyPend_d = bus.key_in;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.key_load) begin
          keyPend_d = bus.key_in;
        end
        if (wordCnt_q == 2'd0 && !inFlight && !mValid_q) begin
          keyOut_d = keyPend_d;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        keyAck  = 1'b1;
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    sReady_d = (state_d == RUN) || ((state_d == DRAIN) && (wordCnt_d != 2'd0));
  end

  // All state registers; reset discards partial blocks, in-flight tags and
  // any pending key, and holds s_ready low until the first edge after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wordCnt_q   <= 2'd0;
      shiftBuf_q  <= '0;
      textOut_q   <= '0;
      textValid_q <= 1'b0;
      delayLine_q <= '0;
      mData_q     <= '0;
      mValid_q    <= 1'b0;
      blocksIn_q  <= '0;
      blocksOut_q <= '0;
      keyOut_q    <= '0;
      keyPend_q   <= '0;
      sReady_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wordCnt_q   <= wordCnt_d;
      shiftBuf_q  <= shiftBuf_d;
      textOut_q   <= textOut_d;
      textValid_q <= textValid_d;
      delayLine_q <= delayLine_d;
      mData_q     <= mData_d;
      mValid_q    <= mValid_d;
      blocksIn_q  <= blocksIn_d;
      blocksOut_q <= blocksOut_d;
      keyOut_q    <= keyOut_d;
      keyPend_q   <= keyPend_d;
      sReady_q    <= sReady_d;
    end
  end

  assign bus.key_ack    = keyAck;
  assign bus.s_ready    = sReady_q;
  assign bus.key_out    = keyOut_q;
  assign bus.text_out   = textOut_q;
  assign bus.text_valid = textValid_q;
  assign bus.m_valid    = mValid_q;
  assign bus.m_data     = mData_q;
  assign bus.blocks_in  = blocksIn_q;
  assign bus.blocks_out = blocksOut_q;

endmodule
